// File: rtl/giant_pkg.sv
// Shared types and constants for the giant sprite pixel stage.
// Palette order is fixed by the sprite artwork's exported index table.
package giant_pkg;

  typedef logic [3:0] pidx_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int PIPE_LAT = 2;

  localparam rgb12_t PALETTE [16] = '{
    rgb12_t'(12'h000), rgb12_t'(12'hFFF), rgb12_t'(12'hF00), rgb12_t'(12'hFC0),
    rgb12_t'(12'h0F0), rgb12_t'(12'h00F), rgb12_t'(12'hF0F), rgb12_t'(12'h0FF),
    rgb12_t'(12'h888), rgb12_t'(12'h444), rgb12_t'(12'hF80), rgb12_t'(12'h08F),
    rgb12_t'(12'h8F0), rgb12_t'(12'hF08), rgb12_t'(12'hCCC), rgb12_t'(12'h222)
  };

endpackage

// File: rtl/giant_blink_ctr.sv
// Counts vsync falling edges and toggles blink_phase every BLINK_FRAMES frames.
// Latency: phase updates on the clk that samples the edge; no backpressure (free-running).
module giant_blink_ctr #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vs_in,
  output logic blink_phase
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  logic       vs_prev;
  logic [7:0] frame_cnt;
  logic       frame_edge;

  assign frame_edge = vs_prev & ~vs_in;

  // vs_prev resets high so releasing reset while vs is low is not a frame edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev     <= 1'b1;
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      if (frame_edge) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt   <= 8'd0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/giant_pixel_pipe.sv
// Giant sprite ROM fetch, palette/colour-key/blink mux and sync alignment to the VGA pins.
// Latency: every output exactly 2 clks after its inputs; no backpressure (one pixel per clk).
module giant_pixel_pipe
  import giant_pkg::*;
#(
  parameter int    ADDR_W        = 12,
  parameter int    SPRITE_PIXELS = 462,
  parameter pidx_t TRANS_IDX     = 4'h0,
  parameter int    BLINK_FRAMES  = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              is_giant,
  input  logic [ADDR_W-1:0] giant_address,
  input  logic [11:0]       bg_rgb,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_n_in,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        Red,
  output logic [3:0]        Green,
  output logic [3:0]        Blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_n_out
);

  logic                in_range;
  logic                in_range_d1;
  rgb12_t              bg_d1;
  rgb12_t              rgb_nxt;
  rgb12_t              rgb_q;
  logic                show;
  logic                blink_phase;
  logic [PIPE_LAT-1:0] hs_sr;
  logic [PIPE_LAT-1:0] vs_sr;
  logic [PIPE_LAT-1:0] blank_sr;

  // S0: the ROM is registered, so its address must leave combinationally.
  assign rom_addr = is_giant ? giant_address : '0;
  assign in_range = is_giant && ({1'b0, giant_address} < (ADDR_W + 1)'(SPRITE_PIXELS));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_range_d1 <= 1'b0;
      bg_d1       <= '0;
    end else begin
      in_range_d1 <= in_range;
      bg_d1       <= bg_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_sr    <= '1;
      vs_sr    <= '1;
      blank_sr <= '0;
    end else begin
      hs_sr    <= {hs_sr[PIPE_LAT-2:0], hs_in};
      vs_sr    <= {vs_sr[PIPE_LAT-2:0], vs_in};
      blank_sr <= {blank_sr[PIPE_LAT-2:0], blank_n_in};
    end
  end

  giant_blink_ctr #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .vs_in      (vs_in),
    .blink_phase(blink_phase)
  );

  // S2: blink_en is used live here, not pipelined, so toggling it acts on the next pixel out.
  always_comb begin
    show    = in_range_d1 && (pidx_t'(rom_data) != TRANS_IDX) && (!blink_en || !blink_phase);
    rgb_nxt = bg_d1;
    if (!blank_sr[0]) begin
      rgb_nxt = '0;
    end else if (show) begin
      rgb_nxt = PALETTE[rom_data];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_nxt;
    end
  end

  assign Red         = rgb_q.r;
  assign Green       = rgb_q.g;
  assign Blue        = rgb_q.b;
  assign hs_out      = hs_sr[PIPE_LAT-1];
  assign vs_out      = vs_sr[PIPE_LAT-1];
  assign blank_n_out = blank_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_giant_pixel_pipe.sv
// Scoreboard bench for giant_pixel_pipe: driver queues expected pixels, monitor checks them 2 clks later.
module tb_giant_pixel_pipe;

  localparam logic [11:0] PAL3 = 12'hFC0;
  localparam logic [11:0] PAL9 = 12'h444;
  localparam logic [11:0] PALA = 12'hF80;
  localparam logic [11:0] BG   = 12'h0F0;
  localparam logic [14:0] RST_OUT = {12'h000, 3'b110};

  typedef struct {
    int          cyc;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
    string       nm;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        is_giant = 1'b0;
  logic [11:0] giant_address = '0;
  logic [11:0] bg_rgb = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_n_in = 1'b0;
  logic        blink_en = 1'b0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  Red, Green, Blue;
  logic        hs_out, vs_out, blank_n_out;

  logic [3:0]  rom [4096];
  exp_t        sb [$];
  exp_t        me;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  giant_pixel_pipe #(
    .ADDR_W       (12),
    .SPRITE_PIXELS(462),
    .TRANS_IDX    (4'h0),
    .BLINK_FRAMES (2)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .is_giant     (is_giant),
    .giant_address(giant_address),
    .bg_rgb       (bg_rgb),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .blank_n_in   (blank_n_in),
    .blink_en     (blink_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .blank_n_out  (blank_n_out)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) rom_data <= rom[rom_addr];

  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      n_tests++;
      if (me.cyc != cyc || {Red, Green, Blue, hs_out, vs_out, blank_n_out} !== {me.rgb, me.hs, me.vs, me.bl}) begin
        n_fail++;
        $display("FAIL %s cyc=%0d(due %0d) got rgb=%h hs=%b vs=%b bl=%b, want rgb=%h hs=%b vs=%b bl=%b",
                 me.nm, cyc, me.cyc, {Red, Green, Blue}, hs_out, vs_out, blank_n_out,
                 me.rgb, me.hs, me.vs, me.bl);
      end
    end
  end

  task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic push(input int c, input logic [11:0] r, input logic h, input logic v,
                      input logic b, input string nm);
    exp_t e;
    e.cyc = c; e.rgb = r; e.hs = h; e.vs = v; e.bl = b; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic drive_now(input logic g, input logic [11:0] a, input logic [11:0] bg,
                           input logic h, input logic v, input logic b,
                           input logic [11:0] er, input string nm);
    is_giant = g; giant_address = a; bg_rgb = bg;
    hs_in = h; vs_in = v; blank_n_in = b;
    push(cyc + 2, er, h, v, b, nm);
  endtask

  task automatic step(input logic g, input logic [11:0] a, input logic [11:0] bg,
                      input logic h, input logic v, input logic b,
                      input logic [11:0] er, input string nm);
    @(posedge Clk); #1;
    drive_now(g, a, bg, h, v, b, er, nm);
  endtask

  task automatic spr_check(input logic vis, input string nm);
    step(1'b1, 12'd5, BG, 1'b1, 1'b1, 1'b1, vis ? PAL3 : BG, nm);
  endtask

  // Filler first so the previous pixel has left S2 before blink_en moves with the vs edge.
  task automatic frame_edge(input logic en);
    step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b0, 12'h000, "vs_pre");
    @(posedge Clk); #1;
    blink_en = en;
    drive_now(1'b0, 12'd0, BG, 1'b1, 1'b0, 1'b0, 12'h000, "vs_lo");
    step(1'b0, 12'd0, BG, 1'b1, 1'b0, 1'b0, 12'h000, "vs_lo");
    step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b0, 12'h000, "vs_hi");
  endtask

  task automatic hold_and_reset();
    repeat (3) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_rst", {Red, Green, Blue, hs_out, vs_out, blank_n_out}, RST_OUT);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_held", {Red, Green, Blue, hs_out, vs_out, blank_n_out}, RST_OUT);
  endtask

  task automatic release_rst(input logic [11:0] er, input string nm);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    push(cyc + 1, 12'h000, 1'b1, 1'b1, 1'b0, "rst_flush");
    drive_now(1'b1, 12'd5, BG, 1'b1, 1'b1, 1'b1, er, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 4'h9;
    rom[5]   = 4'h3;
    rom[7]   = 4'h0;
    rom[461] = 4'hA;
    rom[462] = 4'hB;

    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      is_giant      = 1'($urandom);
      giant_address = 12'($urandom);
      bg_rgb        = 12'($urandom);
      hs_in         = 1'($urandom);
      vs_in         = 1'($urandom);
      blank_n_in    = 1'($urandom);
      blink_en      = 1'($urandom);
      @(negedge Clk);
      chk("rst_rand", {Red, Green, Blue, hs_out, vs_out, blank_n_out}, RST_OUT);
    end
    blink_en = 1'b0;

    release_rst(PAL3, "opaque_rel");
    step(1'b1, 12'd5,   BG,     1'b1, 1'b1, 1'b1, PAL3,    "opaque");
    step(1'b1, 12'd7,   BG,     1'b1, 1'b1, 1'b1, BG,      "trans_idx");
    step(1'b1, 12'd461, 12'h123, 1'b1, 1'b1, 1'b1, PALA,   "last_px");
    step(1'b1, 12'd462, 12'h123, 1'b1, 1'b1, 1'b1, 12'h123, "past_end");
    step(1'b0, 12'd5,   12'h456, 1'b1, 1'b1, 1'b1, 12'h456, "not_giant");
    step(1'b1, 12'd0,   12'h456, 1'b1, 1'b1, 1'b1, PAL9,   "addr0");
    step(1'b1, 12'd5,   BG,     1'b1, 1'b1, 1'b0, 12'h000, "blank_spr");
    step(1'b0, 12'd0,   12'h456, 1'b1, 1'b1, 1'b0, 12'h000, "blank_bg");

    repeat (5)  step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b1, BG, "hs_idle");
    repeat (96) step(1'b0, 12'd0, BG, 1'b0, 1'b1, 1'b1, BG, "hs_pulse");
    repeat (5)  step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b1, BG, "hs_idle");
    repeat (96) step(1'b0, 12'd0, BG, 1'b1, 1'b0, 1'b1, BG, "vs_pulse");
    repeat (5)  step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b1, BG, "vs_idle");

    step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b1, BG, "pre_rst1");
    hold_and_reset();
    blink_en = 1'b1;
    release_rst(PAL3, "blk_f0");
    frame_edge(1'b1); spr_check(1'b1, "blk_f1");
    frame_edge(1'b1); spr_check(1'b0, "blk_f2");
    frame_edge(1'b1); spr_check(1'b0, "blk_f3");
    frame_edge(1'b1); spr_check(1'b1, "blk_f4");
    frame_edge(1'b1); spr_check(1'b1, "blk_f5");
    frame_edge(1'b1); spr_check(1'b0, "blk_f6");
    frame_edge(1'b0); spr_check(1'b1, "en_off_e7");
    step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b1, BG, "fill");
    @(posedge Clk); #1;
    blink_en = 1'b1;
    drive_now(1'b1, 12'd5, BG, 1'b1, 1'b1, 1'b1, BG, "en_on_hid");
    frame_edge(1'b1); spr_check(1'b1, "blk_e8");

    frame_edge(1'b1);
    frame_edge(1'b1);
    frame_edge(1'b1); spr_check(1'b0, "blk_e11");
    step(1'b0, 12'd0, BG, 1'b1, 1'b1, 1'b1, BG, "pre_rst2");
    hold_and_reset();
    release_rst(PAL3, "mid_f0");
    frame_edge(1'b1); spr_check(1'b1, "mid_f1");
    frame_edge(1'b1); spr_check(1'b0, "mid_f2");

    repeat (4) @(posedge Clk);
    @(negedge Clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain left=%0d want=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
